// File: rtl/float_const_sub.sv
// Multi-cycle single-precision float_out = CONST - float_in with start/ready handshake.
// Define FLOAT_CONST_SUB_ROUND_NEAREST_EN for round-to-nearest-even (default truncates).
module float_const_sub #(
  parameter logic [31:0] CONST      = 32'h3FC00000,
  parameter int          SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] float_in,
  output logic [31:0] float_out,
  output logic        ready,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADDSUB = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [4:0]  STEP    = 5'(SHIFT_STEP);
  localparam logic [7:0]  C_EXP   = CONST[30:23];
  localparam logic        C_SUB   = (C_EXP == 8'd0);
  localparam logic [31:0] C_FLUSH =
    C_SUB ? {CONST[31], 31'd0} : CONST;
  localparam logic [26:0] C_SIG   =
    {1'b1, CONST[22:0], 3'b000};

  logic [2:0]         state;
  logic [31:0]        x_q;
  logic               sa, sb, rs;
  logic signed [9:0]  ea, re;
  logic [26:0]        ma, mb, rm;
  logic [4:0]         dcnt;

  // unpack
  logic [7:0]  xe;
  logic [22:0] xm;
  logic        x_nan, x_inf, x_zero, c_ge;
  logic [7:0]  ediff;
  logic [4:0]  dcap;
  logic [26:0] x_sig;

  assign xe     = x_q[30:23];
  assign xm     = x_q[22:0];
  assign x_nan  = (xe == 8'hFF) && (xm != 23'd0);
  assign x_inf  = (xe == 8'hFF) && (xm == 23'd0);
  assign x_zero = (xe == 8'd0);
  assign c_ge   = (C_EXP >= xe);
  assign ediff  = c_ge ? (C_EXP - xe) : (xe - C_EXP);
  assign dcap   = (ediff > 8'd26) ? 5'd26 : ediff[4:0];
  assign x_sig  = {1'b1, xm, 3'b000};

  // align
  logic [4:0]  step;
  logic [26:0] mask, b_sh;

  assign step = (dcnt < STEP) ? dcnt : STEP;
  assign mask = (27'd1 << step) - 27'd1;
  assign b_sh = (mb >> step) | {26'd0, |(mb & mask)};

  // add/sub
  logic [27:0] sum;
  logic        a_ge;
  logic [26:0] dmag;

  assign sum  = {1'b0, ma} + {1'b0, mb};
  assign a_ge = (ma >= mb);
  assign dmag = a_ge ? (ma - mb) : (mb - ma);

  // normalise: up to SHIFT_STEP single-bit shifts per cycle
  logic [26:0]       n_m;
  logic signed [9:0] n_e;

  always_comb begin
    n_m = rm;
    n_e = re;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (!n_m[26]) begin
        n_m = n_m << 1;
        n_e = n_e - 10'sd1;
      end
    end
  end

  // round
  logic [23:0]       m24;
  logic              inc;
  logic [24:0]       m25;
  logic signed [9:0] r_e;
  logic [22:0]       r_f;
  logic [31:0]       r_out;

  assign m24 = rm[26:3];
`ifdef FLOAT_CONST_SUB_ROUND_NEAREST_EN
  assign inc = rm[2] & ((|rm[1:0]) | rm[3]);
`else
  assign inc = 1'b0;
`endif
  assign m25   = {1'b0, m24} + {24'd0, inc};
  assign r_e   = re + 10'(m25[24]);
  assign r_f   = m25[24] ? m25[23:1] : m25[22:0];
  assign r_out = (r_e >= 10'sd255) ?
    {rs, 8'hFF, 23'd0} : {rs, r_e[7:0], r_f};

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      float_out <= 32'h0;
      ready     <= 1'b0;
      x_q       <= 32'h0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      rs        <= 1'b0;
      ea        <= 10'sd0;
      re        <= 10'sd0;
      ma        <= 27'd0;
      mb        <= 27'd0;
      rm        <= 27'd0;
      dcnt      <= 5'd0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_q   <= float_in;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (x_nan || x_inf || x_zero || C_SUB) begin
            ready <= 1'b1;
            state <= S_DONE;
            if (x_nan)
              float_out <= 32'h7FC00000;
            else if (x_inf)
              float_out <= {~x_q[31], 8'hFF, 23'd0};
            else if (x_zero)
              float_out <= C_FLUSH;
            else
              float_out <= {~x_q[31], x_q[30:0]};
          end else begin
            if (c_ge) begin
              sa <= CONST[31];
              ma <= C_SIG;
              ea <= {2'b00, C_EXP};
              sb <= ~x_q[31];
              mb <= x_sig;
            end else begin
              sa <= ~x_q[31];
              ma <= x_sig;
              ea <= {2'b00, xe};
              sb <= CONST[31];
              mb <= C_SIG;
            end
            dcnt  <= dcap;
            state <= (dcap == 5'd0) ? S_ADDSUB : S_ALIGN;
          end
        end
        S_ALIGN: begin
          mb   <= b_sh;
          dcnt <= dcnt - step;
          if (dcnt == step)
            state <= S_ADDSUB;
        end
        S_ADDSUB: begin
          if (sa == sb) begin
            rs    <= sa;
            state <= S_NORM;
            if (sum[27]) begin
              rm <= {sum[27:2], sum[1] | sum[0]};
              re <= ea + 10'sd1;
            end else begin
              rm <= sum[26:0];
              re <= ea;
            end
          end else if (dmag == 27'd0) begin
            float_out <= 32'h0;
            ready     <= 1'b1;
            state     <= S_DONE;
          end else begin
            rs    <= a_ge ? sa : sb;
            rm    <= dmag;
            re    <= ea;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (n_e <= 10'sd0) begin
            float_out <= {rs, 31'd0};
            ready     <= 1'b1;
            state     <= S_DONE;
          end else begin
            rm <= n_m;
            re <= n_e;
            if (n_m[26])
              state <= S_ROUND;
          end
        end
        S_ROUND: begin
          float_out <= r_out;
          ready     <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_const_sub.sv
// Directed bench for float_const_sub: three instances
// (1.5 step 1, 1.5 step 8, 2.0 step 1).
module tb_float_const_sub;

  logic        clk;
  logic        rst;
  logic        start_v [3];
  logic [31:0] fin     [3];
  logic [31:0] fout    [3];
  logic        ready_v [3];
  logic        busy_v  [3];

  int checks;
  int failures;

  float_const_sub #(.CONST(32'h3FC00000), .SHIFT_STEP(1)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .float_in(fin[0]),
    .float_out(fout[0]), .ready(ready_v[0]), .busy(busy_v[0]));

  float_const_sub #(.CONST(32'h3FC00000), .SHIFT_STEP(8)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .float_in(fin[1]),
    .float_out(fout[1]), .ready(ready_v[1]), .busy(busy_v[1]));

  float_const_sub #(.CONST(32'h40000000), .SHIFT_STEP(1)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .float_in(fin[2]),
    .float_out(fout[2]), .ready(ready_v[2]), .busy(busy_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FLOAT_CONST_SUB_ROUND_NEAREST_EN
  localparam logic [31:0] TINY_EXP = 32'h3FC00000;
`else
  localparam logic [31:0] TINY_EXP = 32'h3FBFFFFF;
`endif

  // Holds start until the unit accepts it, then waits for ready.
  // cyc = edges from the capture edge up to the ready cycle.
  task automatic run(input int u, input logic [31:0] x,
                     output logic [31:0] res, output int cyc);
    int guard;
    guard = 0;
    fin[u] = x;
    start_v[u] = 1'b1;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!busy_v[u] && guard < 20);
    start_v[u] = 1'b0;
    cyc = 1;
    while (!ready_v[u] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = fout[u];
    checks++;
    if (!ready_v[u]) begin
      failures++;
      $display("FAIL timeout unit=%0d x=%h got no ready, required ready", u, x);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (fout[u] !== 32'h0) begin
        failures++;
        $display("FAIL reset_out u=%0d got %h required 00000000", u, fout[u]);
      end
      checks++;
      if (ready_v[u] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready u=%0d got %b required 0", u, ready_v[u]);
      end
      checks++;
      if (busy_v[u] !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy u=%0d got %b required 0", u, busy_v[u]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [31:0] xs  [4];
    logic [31:0] exp [4];
    logic [31:0] r;
    int cyc;
    xs  = '{32'h3F000000, 32'h40400000, 32'h3FC00000, 32'hBF000000};
    exp = '{32'h3F800000, 32'hBFC00000, 32'h00000000, 32'h40000000};
    for (int i = 0; i < 4; i++) begin
      run(0, xs[i], r, cyc);
      checks++;
      if (r !== exp[i]) begin
        failures++;
        $display("FAIL basic x=%h got %h required %h", xs[i], r, exp[i]);
      end
      if (i == 0) begin
        checks++;
        if (cyc !== 6) begin
          failures++;
          $display("FAIL latency_half got %0d required 6", cyc);
        end
        checks++;
        if (busy_v[0] !== 1'b1) begin
          failures++;
          $display("FAIL busy_in_done got %b required 1", busy_v[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (ready_v[0] !== 1'b0) begin
          failures++;
          $display("FAIL ready_pulse got %b required 0", ready_v[0]);
        end
        checks++;
        if (busy_v[0] !== 1'b0) begin
          failures++;
          $display("FAIL busy_fall got %b required 0", busy_v[0]);
        end
        checks++;
        if (fout[0] !== exp[0]) begin
          failures++;
          $display("FAIL out_hold got %h required %h", fout[0], exp[0]);
        end
      end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] r;
    int cyc;
    run(0, 32'h33800000, r, cyc);
    checks++;
    if (r !== TINY_EXP) begin
      failures++;
      $display("FAIL tiny_step1 got %h required %h", r, TINY_EXP);
    end
    checks++;
    if (cyc !== 29) begin
      failures++;
      $display("FAIL tiny_step1_lat got %0d required 29", cyc);
    end
    run(1, 32'h33800000, r, cyc);
    checks++;
    if (r !== TINY_EXP) begin
      failures++;
      $display("FAIL tiny_step8 got %h required %h", r, TINY_EXP);
    end
    checks++;
    if (cyc !== 8) begin
      failures++;
      $display("FAIL tiny_step8_lat got %0d required 8", cyc);
    end
  endtask

  task automatic test_specials;
    logic [31:0] xs  [5];
    logic [31:0] exp [5];
    logic [31:0] r;
    int cyc;
    xs  = '{32'h7FC00001, 32'h7F800000, 32'hFF800000,
            32'h00000001, 32'h80000000};
    exp = '{32'h7FC00000, 32'hFF800000, 32'h7F800000,
            32'h3FC00000, 32'h3FC00000};
    for (int i = 0; i < 5; i++) begin
      run(0, xs[i], r, cyc);
      checks++;
      if (r !== exp[i]) begin
        failures++;
        $display("FAIL special x=%h got %h required %h", xs[i], r, exp[i]);
      end
      checks++;
      if (cyc !== 2) begin
        failures++;
        $display("FAIL special_lat x=%h got %0d required 2", xs[i], cyc);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int n_ready;
    logic [31:0] r;
    n_ready = 0;
    r = 32'h0;
    @(posedge clk); #1;
    fin[0] = 32'h40400000;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    fin[0] = 32'h3F000000;
    start_v[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_v[0]) begin
        n_ready++;
        r = fout[0];
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_ready !== 1) begin
      failures++;
      $display("FAIL ignore_count got %0d required 1", n_ready);
    end
    checks++;
    if (r !== 32'hBFC00000) begin
      failures++;
      $display("FAIL ignore_value got %h required BFC00000", r);
    end
  endtask

  task automatic test_reset_mid;
    int n_ready;
    logic [31:0] r;
    int cyc;
    n_ready = 0;
    fin[0] = 32'h33800000;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrst_busy got %b required 0", busy_v[0]);
    end
    checks++;
    if (fout[0] !== 32'h0) begin
      failures++;
      $display("FAIL midrst_out got %h required 00000000", fout[0]);
    end
    for (int i = 0; i < 40; i++) begin
      if (ready_v[0]) n_ready++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_ready !== 0) begin
      failures++;
      $display("FAIL midrst_ready got %0d required 0", n_ready);
    end
    run(0, 32'h3F000000, r, cyc);
    checks++;
    if (r !== 32'h3F800000) begin
      failures++;
      $display("FAIL midrst_next got %h required 3F800000", r);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xs  [10];
    logic [31:0] exp [10];
    logic [31:0] r;
    int cyc;
    xs  = '{32'h3F800000, 32'h3F000000, 32'h40000000, 32'h40400000,
            32'hC0000000, 32'h00000000, 32'hFF800000, 32'h40800000,
            32'h3FE00000, 32'hC0C00000};
    exp = '{32'h3F800000, 32'h3FC00000, 32'h00000000, 32'hBF800000,
            32'h40800000, 32'h40000000, 32'h7F800000, 32'hC0000000,
            32'h3E800000, 32'h41000000};
    for (int i = 0; i < 10; i++) begin
      run(2, xs[i], r, cyc);
      checks++;
      if (r !== exp[i]) begin
        failures++;
        $display("FAIL b2b[%0d] x=%h got %h required %h", i, xs[i], r, exp[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      start_v[u] = 1'b0;
      fin[u] = 32'h0;
    end
    test_reset;
    test_basic;
    test_rounding;
    test_specials;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
